// File: rtl/cpu_pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and
// multi-cycle multiply sequencing, with saturating stall/flush counters.
module cpu_pipeline_ctrl #(
  parameter int MUL_LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_is_mul,
  input  logic [4:0]  id_src1,
  input  logic [4:0]  id_src2,
  input  logic        id_uses_src2,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_dst,
  input  logic        ex_branch_taken,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        bubble_execute,
  output logic        flush_decode,
  output logic        mul_start,
  output logic        mul_done,
  output logic [1:0]  ctrl_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MUL_WAIT   = 2'd2,
    UNUSED     = 2'd3
  } state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LATENCY - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] mul_cnt;
  logic [3:0] mul_cnt_next;
  logic       load_hazard;
  logic       src1_hit;
  logic       src2_hit;

  // Load-use hazard: the load's destination feeds a decode source.
  always_comb begin
    src1_hit    = (ex_dst == id_src1);
    src2_hit    = id_uses_src2 && (ex_dst == id_src2);
    load_hazard = id_valid && ex_is_load && (ex_dst != 5'd0)
                  && (src1_hit || src2_hit);
  end

  // Next-state and control outputs; reset forces every output low.
  always_comb begin
    state_next     = RUN;
    mul_cnt_next   = mul_cnt;
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    bubble_execute = 1'b0;
    flush_decode   = 1'b0;
    mul_start      = 1'b0;
    mul_done       = 1'b0;
    case (state)
      RUN, LOAD_STALL: begin
        mul_cnt_next = 4'd0;
        if (ex_branch_taken) begin
          flush_decode   = 1'b1;
          bubble_execute = 1'b1;
          state_next     = RUN;
        end else if (load_hazard) begin
          stall_fetch    = 1'b1;
          stall_decode   = 1'b1;
          bubble_execute = 1'b1;
          state_next     = LOAD_STALL;
        end else if (id_valid && id_is_mul) begin
          mul_start      = 1'b1;
          stall_fetch    = 1'b1;
          stall_decode   = 1'b1;
          bubble_execute = 1'b1;
          mul_cnt_next   = MUL_LOAD;
          state_next     = MUL_WAIT;
        end else begin
          state_next     = RUN;
        end
      end
      MUL_WAIT: begin
        if (ex_branch_taken) begin
          flush_decode   = 1'b1;
          bubble_execute = 1'b1;
          mul_cnt_next   = 4'd0;
          state_next     = RUN;
        end else if (mul_cnt != 4'd0) begin
          stall_fetch    = 1'b1;
          stall_decode   = 1'b1;
          bubble_execute = 1'b1;
          mul_cnt_next   = mul_cnt - 4'd1;
          state_next     = MUL_WAIT;
        end else begin
          mul_done       = 1'b1;
          state_next     = RUN;
        end
      end
      default: begin
        mul_cnt_next = 4'd0;
        state_next   = RUN;
      end
    endcase
    if (reset) begin
      stall_fetch    = 1'b0;
      stall_decode   = 1'b0;
      bubble_execute = 1'b0;
      flush_decode   = 1'b0;
      mul_start      = 1'b0;
      mul_done       = 1'b0;
      mul_cnt_next   = 4'd0;
      state_next     = RUN;
    end
  end

  // State and multiply countdown registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      mul_cnt <= 4'd0;
    end else begin
      state   <= state_next;
      mul_cnt <= mul_cnt_next;
    end
  end

  // Saturating event counters for stall and flush cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_decode && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (flush_decode && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

  assign ctrl_state = state;

endmodule

// File: tb/tb_cpu_pipeline_ctrl.sv
// Scoreboard bench for cpu_pipeline_ctrl: a cycle-level reference
// model predicts outputs, a negedge monitor compares them.
module tb_cpu_pipeline_ctrl;

  localparam int L = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic        id_is_mul = 1'b0;
  logic [4:0]  id_src1 = 5'd0;
  logic [4:0]  id_src2 = 5'd0;
  logic        id_uses_src2 = 1'b0;
  logic        ex_is_load = 1'b0;
  logic [4:0]  ex_dst = 5'd0;
  logic        ex_branch_taken = 1'b0;
  logic        stall_fetch;
  logic        stall_decode;
  logic        bubble_execute;
  logic        flush_decode;
  logic        mul_start;
  logic        mul_done;
  logic [1:0]  ctrl_state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  cpu_pipeline_ctrl #(.MUL_LATENCY(L)) dut (
    .clock(clock),
    .reset(reset),
    .id_valid(id_valid),
    .id_is_mul(id_is_mul),
    .id_src1(id_src1),
    .id_src2(id_src2),
    .id_uses_src2(id_uses_src2),
    .ex_is_load(ex_is_load),
    .ex_dst(ex_dst),
    .ex_branch_taken(ex_branch_taken),
    .stall_fetch(stall_fetch),
    .stall_decode(stall_decode),
    .bubble_execute(bubble_execute),
    .flush_decode(flush_decode),
    .mul_start(mul_start),
    .mul_done(mul_done),
    .ctrl_state(ctrl_state),
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: mode 0 run, 1 load stall, 2 multiply wait;
  // wait_k counts multiply-wait cycles already entered (1..L).
  int mode = 0;
  int wait_k = 0;
  int m_sc = 0;
  int m_fc = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one prediction per cycle and compare.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ctl", int'({stall_fetch, stall_decode, bubble_execute,
                         flush_decode, mul_start, mul_done}), int'(e.ctl));
      check("ctrl_state", int'(ctrl_state), int'(e.st));
      check("stall_cnt", int'(stall_cnt), int'(e.sc));
      check("flush_cnt", int'(flush_cnt), int'(e.fc));
    end
  end

  task automatic drive(input logic rst, input logic v, input logic m,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic u2, input logic ld,
                       input logic [4:0] d, input logic br);
    exp_t e;
    bit sf, sd, bx, fd, ms, md, hz;
    int nm;
    @(posedge clock);
    #1;
    reset = rst; id_valid = v; id_is_mul = m; id_src1 = s1;
    id_src2 = s2; id_uses_src2 = u2; ex_is_load = ld; ex_dst = d;
    ex_branch_taken = br;
    {sf, sd, bx, fd, ms, md} = 6'b0;
    if (rst) begin
      mode = 0; wait_k = 0; m_sc = 0; m_fc = 0;
      e.ctl = 6'd0; e.st = 2'd0; e.sc = 16'd0; e.fc = 16'd0;
      q.push_back(e);
      return;
    end
    e.st = 2'(mode);
    e.sc = 16'(m_sc);
    e.fc = 16'(m_fc);
    hz = v && ld && (d != 0) && (d == s1 || (u2 && d == s2));
    nm = 0;
    if (mode == 2) begin
      if (br) begin fd = 1; bx = 1; end
      else if (wait_k == L) md = 1;
      else begin sf = 1; sd = 1; bx = 1; wait_k++; nm = 2; end
    end else begin
      if (br) begin fd = 1; bx = 1; end
      else if (hz) begin sf = 1; sd = 1; bx = 1; nm = 1; end
      else if (v && m) begin
        ms = 1; sf = 1; sd = 1; bx = 1; nm = 2; wait_k = 1;
      end
    end
    e.ctl = {sf, sd, bx, fd, ms, md};
    q.push_back(e);
    if (sd && m_sc < 65535) m_sc++;
    if (fd && m_fc < 65535) m_fc++;
    mode = nm;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset held with noisy inputs
    for (int i = 0; i < 4; i++)
      drive(1, 1, 1, 5'd3, 5'd3, 1, 1, 5'd3, 1'(i));
    // load-use on src1
    drive(0, 1, 0, 5'd3, 5'd0, 0, 1, 5'd3, 0);
    drive(0, 1, 0, 5'd3, 5'd0, 0, 0, 5'd0, 0);
    idle(2);
    // x0 destination and unused src2 never stall
    drive(0, 1, 0, 5'd0, 5'd0, 0, 1, 5'd0, 0);
    drive(0, 1, 0, 5'd1, 5'd5, 0, 1, 5'd5, 0);
    drive(0, 1, 0, 5'd1, 5'd5, 1, 1, 5'd5, 0);
    idle(2);
    // full multiply
    drive(0, 1, 1, 5'd1, 5'd2, 1, 0, 5'd0, 0);
    idle(6);
    // branch beats multiply in decode
    drive(0, 1, 1, 5'd1, 5'd2, 1, 0, 5'd0, 1);
    idle(2);
    // branch aborts multiply wait
    drive(0, 1, 1, 5'd1, 5'd2, 1, 0, 5'd0, 0);
    idle(1);
    drive(0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1);
    idle(6);
    // reset in the middle of a multiply
    drive(0, 1, 1, 5'd1, 5'd2, 1, 0, 5'd0, 0);
    idle(1);
    drive(1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    idle(6);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 8,
            $urandom_range(0, 9) < 3,
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 9) < 4,
            5'($urandom_range(0, 3)),
            $urandom_range(0, 9) == 0);
    end
    // sustained hazard saturates stall_cnt
    for (int i = 0; i < 70000; i++)
      drive(0, 1, 0, 5'd3, 5'd0, 0, 1, 5'd3, 0);
    idle(3);
    @(posedge clock);
    @(negedge clock);
    #1;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_pipeline_ctrl.md
CPU_PIPELINE_CTRL -- requirements
Module: cpu_pipeline_ctrl

Interface
REQ-001 SHALL have parameter MUL_LATENCY, default 4, legal range 2..15: total stall cycles charged to one multiply.
REQ-002 SHALL have port clock  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port id_valid  in  1  decode stage holds a real instruction.
REQ-005 SHALL have port id_is_mul  in  1  decode instruction is an R-type MUL.
REQ-006 SHALL have port id_src1  in  5  decode source register A index.
REQ-007 SHALL have port id_src2  in  5  decode source register B index.
REQ-008 SHALL have port id_uses_src2  in  1  decode instruction reads register B (R-type).
REQ-009 SHALL have port ex_is_load  in  1  execute stage holds an M-type load.
REQ-010 SHALL have port ex_dst  in  5  execute stage destination register.
REQ-011 SHALL have port ex_branch_taken  in  1  execute stage resolved a taken B-type branch.
REQ-012 SHALL have port stall_fetch  out  1  hold PC and fetch register.
REQ-013 SHALL have port stall_decode  out  1  hold decode register.
REQ-014 SHALL have port bubble_execute  out  1  load execute control with commit=0, reg_write=0, mem_to_reg=0.
REQ-015 SHALL have port flush_decode  out  1  clear decode register to a bubble.
REQ-016 SHALL have port mul_start  out  1  one-cycle pulse: multiplier latches operands.
REQ-017 SHALL have port mul_done  out  1  one-cycle pulse: multiply result valid, decode may advance.
REQ-018 SHALL have port ctrl_state  out  2  current state: RUN=0, LOAD_STALL=1, MUL_WAIT=2; 3 unused.
REQ-019 SHALL have port stall_cnt  out  16  saturating count of cycles with stall_decode=1.
REQ-020 SHALL have port flush_cnt  out  16  saturating count of cycles with flush_decode=1.

Function
REQ-021 load_hazard SHALL be id_valid & ex_is_load & (ex_dst!=0) & ((ex_dst==id_src1) | (id_uses_src2 & ex_dst==id_src2)).
REQ-022 Priority, evaluated each cycle in RUN: ex_branch_taken > load_hazard > (id_valid & id_is_mul).
REQ-023 RUN, ex_branch_taken=1: flush_decode=1, bubble_execute=1, stalls=0, no mul_start; next state RUN.
REQ-024 RUN, load_hazard (no branch): stall_fetch=stall_decode=bubble_execute=1, same cycle (combinational); next state LOAD_STALL.
REQ-025 LOAD_STALL: all stall/bubble outputs 0; decode re-evaluated as in RUN (REQ-022 to REQ-026) in the same cycle; next state RUN unless REQ-024 or REQ-026 applies.
REQ-026 RUN, id_valid & id_is_mul, no branch, no hazard: mul_start=1, stall_fetch=stall_decode=bubble_execute=1; mul_cnt (4 bits) loaded MUL_LATENCY-1; next state MUL_WAIT.
REQ-027 MUL_WAIT, mul_cnt!=0: stall_fetch=stall_decode=bubble_execute=1; mul_cnt decrements.
REQ-028 MUL_WAIT, mul_cnt==0: mul_done=1, stalls=0, bubble_execute=0; next state RUN.
REQ-029 Result: mul_done asserts exactly MUL_LATENCY cycles after mul_start; stall_decode high for exactly MUL_LATENCY cycles.
REQ-030 MUL_WAIT, ex_branch_taken=1: abort; flush_decode=1, bubble_execute=1, no mul_done, mul_cnt cleared; next state RUN.
REQ-031 stall_cnt increments by 1 in each cycle stall_decode=1; flush_cnt in each cycle flush_decode=1; both hold at 16'hFFFF (no wrap).
REQ-032 mul_start and mul_done SHALL never be high in the same cycle.
REQ-033 Unused state 3 SHALL transition to RUN with all control outputs 0.

Reset
REQ-034 While reset=1: state RUN, mul_cnt=0, stall_cnt=0, flush_cnt=0, and all 1-bit outputs 0, regardless of inputs.
REQ-035 Reset asserted mid-MUL_WAIT or mid-LOAD_STALL SHALL abort immediately with no mul_done pulse.
REQ-036 First rising edge after reset deassertion SHALL evaluate from RUN.

Verification
REQ-037 ex_is_load=1, ex_dst=3, id_valid=1, id_src1=3 -> one cycle stall_fetch=stall_decode=bubble_execute=1, ctrl_state 0->1->0, stall_cnt=1.
REQ-038 ex_is_load=1, ex_dst=0, id_src1=0 -> no stall, ctrl_state stays 0; ex_dst=5, id_src2=5, id_uses_src2=0 -> no stall.
REQ-039 MUL_LATENCY=4, mul in decode at cycle t -> mul_start at t, stall t..t+3, mul_done at t+4, ctrl_state=2 for t+1..t+4, stall_cnt=4.
REQ-040 Mul in decode and ex_branch_taken same cycle -> flush_decode=1, no mul_start, ctrl_state stays 0, flush_cnt=1; branch at t+2 during MUL_WAIT -> abort, no mul_done, RUN at t+3.
REQ-041 reset pulsed at t+2 of a multiply -> all outputs 0 immediately, counters 0, no mul_done afterwards.
REQ-042 Hold load hazard/mul stall for 70000 cycles -> stall_cnt saturates at 16'hFFFF and holds.
